// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the step datapath and the top-level controller.
package seq_div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    // Quotient and remainder are filled with this bit on divide-by-zero
    localparam logic DBZ_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step of the divider.
// Purely combinational so it can be exercised in isolation.
module div_step
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   p_i,
    input  logic [DW-1:0] q_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   p_o,
    output logic [DW-1:0] q_o
);

    logic [VW:0] t;

    // The partial remainder never exceeds VW bits between steps,
    // so its top bit carries no information into the shift.
    logic unused_p_msb;
    assign unused_p_msb = p_i[VW];

    // Shift in the next dividend bit and subtract when it fits
    always_comb begin
        t = {p_i[VW-1:0], q_i[DW-1]};
        if (t >= {1'b0, d_i}) begin
            p_o = t - {1'b0, d_i};
            q_o = {q_i[DW-2:0], 1'b1};
        end else begin
            p_o = t;
            q_o = {q_i[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Start/done unsigned divider retiring one quotient bit per clock.
// Holds the FSM, iteration counter, operand and result registers.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = $clog2(DW);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [VW:0]   p_q;
    logic [VW:0]   p_d;
    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [VW-1:0] d_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          dbz_q;

    div_step #(
        .DW (DW),
        .VW (VW)
    ) u_step (
        .p_i (p_q),
        .q_i (q_q),
        .d_i (d_q),
        .p_o (p_d),
        .q_o (q_d)
    );

    // Controller: accept, iterate DW steps, publish results on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            state_q <= DONE;
                            quo_q   <= {DW{DBZ_FILL}};
                            rem_q   <= {VW{DBZ_FILL}};
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            q_q     <= dividend;
                            p_q     <= '0;
                            d_q     <= divisor;
                            cnt_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= DONE;
                        quo_q   <= q_d;
                        rem_q   <= p_d[VW-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences,
// and an exhaustive sweep of the division invariant.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int total = 0;
    int bad   = 0;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation, wait for done; busy_cnt counts busy cycles before done
    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                          output int lat, output int busy_cnt, output bit ok);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        ok       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_vec(input vec_t v, input string tag);
        int lat;
        int bc;
        bit ok;
        run_op(v.dd, v.dv, lat, bc, ok);
        check({tag, " latency"}, lat, v.edbz ? 0 : 8);
        check({tag, " busy cycles"}, bc, v.edbz ? 0 : 8);
        check({tag, " quotient"}, int'(quotient), int'(v.eq));
        check({tag, " remainder"}, int'(remainder), int'(v.er));
        check({tag, " dbz"}, int'(dbz), int'(v.edbz));
        check({tag, " busy at done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, " done one cycle"}, int'(done), 0);
        check({tag, " quotient held"}, int'(quotient), int'(v.eq));
    endtask

    initial begin
        int lat;
        int bc;
        int nd;
        int d1;
        int d2;
        bit ok;
        vec_t v;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
        vecs[3] = '{8'd225, 4'd1,  8'd225, 4'd0,  1'b0};
        vecs[4] = '{8'd100, 4'd0,  8'hFF,  4'hF,  1'b1};
        vecs[5] = '{8'd10,  4'd3,  8'd3,   4'd1,  1'b0};
        vecs[6] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        vecs[7] = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
        vecs[8] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[9] = '{8'd7,   4'd0,  8'hFF,  4'hF,  1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset dbz", int'(dbz), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle done", int'(done), 0);

        for (int i = 0; i < 10; i++) begin
            do_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse during RUN must be ignored
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd    = 0;
        d1    = -1;
        for (int k = 0; k < 20; k++) begin
            if (k == 2) begin
                dividend = 8'd50;
                divisor  = 4'd5;
                start    = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = k;
                    check("ign quotient", int'(quotient), 28);
                    check("ign remainder", int'(remainder), 4);
                end
            end
            @(negedge clk);
        end
        check("ign done count", nd, 1);
        check("ign latency", d1, 8);

        // Start held high: second op accepted in the DONE cycle
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd5;
        d1 = -1;
        d2 = -1;
        for (int k = 0; k < 30; k++) begin
            if (k == 9) check("held busy after accept", int'(busy), 1);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    check("held q1", int'(quotient), 28);
                    check("held r1", int'(remainder), 4);
                end else if (d2 < 0) begin
                    d2 = k;
                    check("held q2", int'(quotient), 10);
                    check("held r2", int'(remainder), 0);
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("held first done", d1, 8);
        check("held second done", d2, 17);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort quotient", int'(quotient), 0);
        check("abort remainder", int'(remainder), 0);
        check("abort dbz", int'(dbz), 0);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("abort no done", nd, 0);
        v = '{8'd9, 4'd2, 8'd4, 4'd1, 1'b0};
        do_vec(v, "post abort");

        // Every dividend against every non-zero divisor
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a), 4'(b), lat, bc, ok);
                if (!ok) begin
                    check($sformatf("sweep %0d/%0d timeout", a, b), 0, 1);
                end else begin
                    check($sformatf("sweep %0d/%0d inv", a, b),
                          int'((int'(quotient) * b + int'(remainder) == a)
                               && (int'(remainder) < b)),
                          1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
